// File: rtl/misuratore_durata_impulso_if.sv
// soc/eoc handshake bundle between the pulse-width meter and the
// downstream pulse-former that consumes the measured width.
interface misuratore_durata_impulso_if #(
  parameter int W = 8
);
  logic         soc;
  logic         eoc;
  logic [W-1:0] numero;
  logic         timeout;

  modport master (
    output soc,
    input  eoc,
    input  numero,
    input  timeout
  );

  modport slave (
    input  soc,
    output eoc,
    output numero,
    output timeout
  );
endinterface

// File: rtl/misuratore_durata_impulso.sv
// Pulse-width meter: on soc, waits for the next complete high pulse on
// pulse_in and returns its width in clocks, clamped to [1, 2**W-1].
module misuratore_durata_impulso #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pulse_in,
  misuratore_durata_impulso_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_RISE,
    S_MEAS,
    S_DONE
  } state_e;

  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [W-1:0]  CNT_ONE = W'(1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [W-1:0]  numero_q, numero_d;
  logic          tmo_q, tmo_d;
  logic          eoc_q, eoc_d;
  logic          in_s;

  assign in_s        = sync_q[1];
  assign bus.eoc     = eoc_q;
  assign bus.numero  = numero_q;
  assign bus.timeout = tmo_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      numero_q <= CNT_ONE;
      tmo_q    <= 1'b0;
      eoc_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      numero_q <= numero_d;
      tmo_q    <= tmo_d;
      eoc_q    <= eoc_d;
    end
  end

  // Results are only loaded on the edge where eoc rises.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    numero_d = numero_q;
    tmo_d    = tmo_q;
    eoc_d    = eoc_q;
    unique case (state_q)
      S_IDLE: begin
        eoc_d = 1'b1;
        if (bus.soc) begin
          state_d = S_ARM;
          eoc_d   = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_ARM: begin
        tcnt_d = tcnt_q + T_ONE;
        if (tcnt_q == T_LAST) begin
          state_d  = S_DONE;
          numero_d = CNT_ONE;
          tmo_d    = 1'b1;
          eoc_d    = 1'b1;
        end else if (!in_s) begin
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        tcnt_d = tcnt_q + T_ONE;
        if (in_s) begin
          state_d = S_MEAS;
          cnt_d   = CNT_ONE;
        end else if (tcnt_q == T_LAST) begin
          state_d  = S_DONE;
          numero_d = CNT_ONE;
          tmo_d    = 1'b1;
          eoc_d    = 1'b1;
        end
      end
      S_MEAS: begin
        if (!in_s || cnt_q == CNT_MAX) begin
          state_d  = S_DONE;
          numero_d = cnt_q;
          tmo_d    = 1'b0;
          eoc_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        eoc_d = 1'b1;
        if (!bus.soc) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        eoc_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_misuratore_durata_impulso.sv
// Randomized bench for the pulse-width meter against a
// waveform-level reference model.
module tb_misuratore_durata_impulso;
  localparam int W   = 8;
  localparam int TMO = 20;

  logic clock = 1'b0;
  logic reset;
  logic pulse_in;

  always #5 clock = ~clock;

  misuratore_durata_impulso_if #(.W(W)) bus ();

  misuratore_durata_impulso #(
    .W(W),
    .TIMEOUT(TMO),
    .TW(16)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .pulse_in(pulse_in),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit p [512];
  bit lvl0;
  int ref_num = 1;
  int ref_tmo = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Line value seen by the FSM at edge k (two-flop delay).
  function automatic bit s_at(input int k);
    return (k < 2) ? lvl0 : p[k-2];
  endfunction

  // Edge 0 samples soc; returns edge where eoc rises and the result.
  function automatic void model(output int done, output int num,
                                output int tmo);
    int a = -1;
    int r = -1;
    int n = 0;
    for (int k = 1; k < TMO; k++)
      if (!s_at(k)) begin a = k; break; end
    if (a > 0)
      for (int k = a + 1; k <= TMO; k++)
        if (s_at(k)) begin r = k; break; end
    if (r < 0) begin
      done = TMO; num = 1; tmo = 1;
      return;
    end
    while (n < 255 && s_at(r + n)) n++;
    done = r + n; num = n; tmo = 0;
  endfunction

  task automatic trial(input int t, input int g, input int w,
                       input bit drop);
    int done, num, tmo, obs;
    bit relapse;
    for (int i = 0; i < 512; i++)
      p[i] = (i < t) || (i >= t + g && i < t + g + w);
    lvl0 = (t > 0);
    model(done, num, tmo);
    bus.soc = 1'b0;
    pulse_in = lvl0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_eoc", bus.eoc, 1);
    chk("idle_numero_hold", bus.numero, ref_num);
    chk("idle_timeout_hold", bus.timeout, ref_tmo);
    obs = -1;
    relapse = 1'b0;
    for (int k = 0; k <= done + 3; k++) begin
      @(negedge clock);
      pulse_in = p[k];
      bus.soc = drop ? (k < 2) : 1'b1;
      @(posedge clock);
      #1;
      if (k == 0) chk("eoc_fall", bus.eoc, 0);
      else if (obs < 0 && bus.eoc === 1'b1) obs = k;
      else if (obs >= 0 && bus.eoc !== 1'b1) relapse = 1'b1;
    end
    chk("done_edge", obs, done);
    chk("numero", bus.numero, num);
    chk("timeout", bus.timeout, tmo);
    chk("no_restart", relapse, 0);
    ref_num = num;
    ref_tmo = tmo;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.soc = 1'b0;
    pulse_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.soc = 1'b1;
    repeat ($urandom_range(3, 12)) begin
      @(negedge clock);
      pulse_in = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_eoc", bus.eoc, 1);
    chk("rst_numero", bus.numero, 1);
    chk("rst_timeout", bus.timeout, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_eoc", bus.eoc, 1);
    @(negedge clock);
    reset = 1'b0;
    bus.soc = 1'b0;
    ref_num = 1;
    ref_tmo = 0;

    trial(0, 3, 5, 1'b0);
    trial(3, 2, 7, 1'b0);
    trial(0, 40, 5, 1'b0);
    trial(0, 4, 300, 1'b0);
    trial(2, 1, 10, 1'b1);

    @(negedge clock);
    bus.soc = 1'b1;
    pulse_in = 1'b0;
    repeat (4) @(negedge clock);
    pulse_in = 1'b1;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("meas_rst_eoc", bus.eoc, 1);
    chk("meas_rst_numero", bus.numero, 1);
    chk("meas_rst_timeout", bus.timeout, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.soc = 1'b0;
    pulse_in = 1'b0;
    ref_num = 1;
    ref_tmo = 0;
    trial(0, 2, 9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int t, g, w;
      bit drop;
      t = $urandom_range(0, 4);
      g = $urandom_range(1, 28);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300)
                                      : $urandom_range(1, 40);
      drop = ($urandom_range(0, 3) == 0);
      trial(t, g, w, drop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
